// File: rtl/track_sel_ctrl_if.sv
// ---------------------------------------------------------------------------
// track_sel_ctrl_if
//   Bundles the signals between the track-selection controller, the user
//   inputs and the pair of downstream BCD digit counters.
//
//   Signals
//     up_btn, down_btn : debounced button levels (increment / decrement)
//     next_pulse       : one-cycle end-of-track advance request
//     clr_req          : level request to zero the selection
//     units_q, tens_q  : current BCD digits read back from the counters
//     inc, dec         : count direction command to both digit counters
//     ena_u, ena_t     : units / tens counter enables
//     clr              : synchronous clear pulse to both digit counters
//     busy             : controller is anywhere other than idle
//     at_limit         : one-cycle pulse when a step is refused
//     state_dbg        : current controller state, for observation only
//
//   Command protocol: there is no back-pressure. Each command is a
//   single-cycle pulse on inc/dec (+ enables) or clr; the counters act on
//   it at the rising edge that ends that cycle, and the new digits must be
//   visible on units_q/tens_q in the following cycle. The controller never
//   issues two commands back to back (a quiet cycle always separates them),
//   so the counters always settle before the next decision reads them.
//
//   Modports
//     master : user / environment side (drives requests and digits)
//     slave  : controller side (drives commands and status)
// ---------------------------------------------------------------------------
interface track_sel_ctrl_if;
  logic       up_btn;
  logic       down_btn;
  logic       next_pulse;
  logic       clr_req;
  logic [3:0] units_q;
  logic [3:0] tens_q;
  logic       inc;
  logic       dec;
  logic       ena_u;
  logic       ena_t;
  logic       clr;
  logic       busy;
  logic       at_limit;
  logic [1:0] state_dbg;

  modport master (
    output up_btn, down_btn, next_pulse, clr_req, units_q, tens_q,
    input  inc, dec, ena_u, ena_t, clr, busy, at_limit, state_dbg
  );

  modport slave (
    input  up_btn, down_btn, next_pulse, clr_req, units_q, tens_q,
    output inc, dec, ena_u, ena_t, clr, busy, at_limit, state_dbg
  );
endinterface

// File: rtl/track_sel_ctrl.sv
// ---------------------------------------------------------------------------
// track_sel_ctrl
//   Track-number selection controller. Turns button presses, held-button
//   auto-repeat, end-of-track advance pulses and clear requests into
//   single-cycle commands for a pair of cascaded BCD counters, refusing
//   steps that would run past 00 or the configured upper limit.
//
//   Parameters
//     MAX_TENS, MAX_UNITS : BCD digits of the highest selectable track
//     DELAY               : hold cycles before the first auto-repeat
//     PERIOD              : cycles between subsequent auto-repeats
//
//   Ports
//     clk  : rising-edge clock
//     rst  : synchronous, active-high reset
//     bus  : track_sel_ctrl_if.slave (requests in, commands/status out)
//
//   States
//     IDLE   : waiting; arbitrates clr_req > pending next > up edge > down edge
//     STEP   : the one cycle in which a command is on the outputs
//     SETTLE : one quiet cycle so the counters' new value is visible
//     HOLD   : a button is still held; counts down to the next auto-repeat
//
//   All outputs are registered: the decision taken in a cycle is driven
//   on the outputs during the following (STEP) cycle.
// ---------------------------------------------------------------------------
module track_sel_ctrl #(
  parameter logic [3:0] MAX_TENS  = 4'd9,
  parameter logic [3:0] MAX_UNITS = 4'd9,
  parameter int         DELAY     = 16,
  parameter int         PERIOD    = 4
) (
  input  logic             clk,
  input  logic             rst,
  track_sel_ctrl_if.slave  bus
);

  // Timer sized to hold the larger of the two reload values without wrap.
  localparam int TMAX = (DELAY > PERIOD) ? DELAY : PERIOD;
  localparam int TW   = (TMAX < 1) ? 1 : $clog2(TMAX + 1);

  localparam logic [TW-1:0] DELAY_LD  = TW'(DELAY);
  localparam logic [TW-1:0] PERIOD_LD = TW'(PERIOD);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);

  // FSM state encoding
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STEP   = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  // Origin of the command currently being served
  localparam logic [1:0] SRC_UP  = 2'd0;
  localparam logic [1:0] SRC_DN  = 2'd1;
  localparam logic [1:0] SRC_NXT = 2'd2;
  localparam logic [1:0] SRC_CLR = 2'd3;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  logic [1:0]    r_state;
  logic [1:0]    r_src;
  logic [TW-1:0] r_timer;
  logic          r_repeat;    // at least one auto-repeat since the press
  logic          r_pend;      // one-deep pending next_pulse
  logic          r_up_d;      // previous up_btn level (edge detect)
  logic          r_dn_d;      // previous down_btn level (edge detect)
  logic          r_up_lock;   // up_btn was held through reset
  logic          r_dn_lock;   // down_btn was held through reset

  logic          r_inc;
  logic          r_dec;
  logic          r_ena_u;
  logic          r_ena_t;
  logic          r_clr;
  logic          r_busy;
  logic          r_at_limit;

  // -------------------------------------------------------------------------
  // Combinational helpers
  // -------------------------------------------------------------------------
  logic          w_up_rise;
  logic          w_dn_rise;
  logic          w_at_max;
  logic          w_at_zero;
  logic          w_units_9;
  logic          w_units_0;
  logic          w_next_req;
  logic          w_src_held;
  logic          w_src_blocked;

  logic [1:0]    w_state_nxt;
  logic [1:0]    w_src_nxt;
  logic [TW-1:0] w_timer_nxt;
  logic          w_repeat_nxt;
  logic          w_pend_nxt;
  logic          w_issue;
  logic          w_lim;

  logic          w_inc;
  logic          w_dec;
  logic          w_ena_u;
  logic          w_ena_t;
  logic          w_clr;

  // A button that was already held when reset released must be let go and
  // pressed again before it counts; otherwise reset would be followed by a
  // spurious step from the old press.
  assign w_up_rise = bus.up_btn   & ~r_up_d & ~r_up_lock;
  assign w_dn_rise = bus.down_btn & ~r_dn_d & ~r_dn_lock;

  assign w_at_max  = (bus.tens_q == MAX_TENS) && (bus.units_q == MAX_UNITS);
  assign w_at_zero = (bus.tens_q == 4'd0) && (bus.units_q == 4'd0);
  assign w_units_9 = (bus.units_q == 4'd9);
  assign w_units_0 = (bus.units_q == 4'd0);

  // A next request is either one remembered from a busy period or a fresh
  // pulse arriving while the controller can act on it directly.
  assign w_next_req = r_pend | bus.next_pulse;

  // Only button-originated commands auto-repeat.
  assign w_src_held = ((r_src == SRC_UP) && bus.up_btn) ||
                      ((r_src == SRC_DN) && bus.down_btn);

  assign w_src_blocked = (r_src == SRC_UP) ? w_at_max : w_at_zero;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin : fsm_next
    w_state_nxt  = r_state;
    w_src_nxt    = r_src;
    w_timer_nxt  = r_timer;
    w_repeat_nxt = r_repeat;
    w_pend_nxt   = r_pend | bus.next_pulse;
    w_issue      = 1'b0;
    w_lim        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.clr_req) begin
          w_issue      = 1'b1;
          w_src_nxt    = SRC_CLR;
          w_state_nxt  = S_STEP;
          w_repeat_nxt = 1'b0;
        end else if (w_next_req) begin
          // At the limit a next request wraps by clearing, never refused.
          w_issue      = 1'b1;
          w_src_nxt    = SRC_NXT;
          w_state_nxt  = S_STEP;
          w_repeat_nxt = 1'b0;
          w_pend_nxt   = 1'b0;
        end else if (w_up_rise && !w_dn_rise) begin
          if (w_at_max) begin
            w_lim = 1'b1;
          end else begin
            w_issue      = 1'b1;
            w_src_nxt    = SRC_UP;
            w_state_nxt  = S_STEP;
            w_repeat_nxt = 1'b0;
          end
        end else if (w_dn_rise && !w_up_rise) begin
          if (w_at_zero) begin
            w_lim = 1'b1;
          end else begin
            w_issue      = 1'b1;
            w_src_nxt    = SRC_DN;
            w_state_nxt  = S_STEP;
            w_repeat_nxt = 1'b0;
          end
        end
      end

      S_STEP: begin
        w_state_nxt = S_SETTLE;
      end

      S_SETTLE: begin
        if (w_src_held) begin
          // The very first wait after a press uses DELAY; once the button
          // has repeated, every further wait uses PERIOD.
          w_state_nxt = S_HOLD;
          w_timer_nxt = r_repeat ? PERIOD_LD : DELAY_LD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_HOLD: begin
        if (bus.clr_req) begin
          w_issue     = 1'b1;
          w_src_nxt   = SRC_CLR;
          w_state_nxt = S_STEP;
        end else if (w_next_req) begin
          w_issue     = 1'b1;
          w_src_nxt   = SRC_NXT;
          w_state_nxt = S_STEP;
          w_pend_nxt  = 1'b0;
        end else if (!w_src_held) begin
          w_state_nxt = S_IDLE;
        end else if (r_timer <= TIMER_ONE) begin
          // Limit is checked again at every repeat: the value may have
          // reached it on the previous step.
          if (w_src_blocked) begin
            w_lim       = 1'b1;
            w_timer_nxt = PERIOD_LD;
          end else begin
            w_issue      = 1'b1;
            w_state_nxt  = S_STEP;
            w_repeat_nxt = 1'b1;
          end
        end else begin
          w_timer_nxt = r_timer - TIMER_ONE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Command decode for the command chosen this cycle
  // -------------------------------------------------------------------------
  always_comb begin : cmd_decode
    w_inc   = 1'b0;
    w_dec   = 1'b0;
    w_ena_u = 1'b0;
    w_ena_t = 1'b0;
    w_clr   = 1'b0;

    if (w_issue) begin
      case (w_src_nxt)
        SRC_UP: begin
          w_inc   = 1'b1;
          w_ena_u = 1'b1;
          w_ena_t = w_units_9;   // carry into tens
        end
        SRC_DN: begin
          w_dec   = 1'b1;
          w_ena_u = 1'b1;
          w_ena_t = w_units_0;   // borrow from tens
        end
        SRC_NXT: begin
          if (w_at_max) begin
            w_clr = 1'b1;
          end else begin
            w_inc   = 1'b1;
            w_ena_u = 1'b1;
            w_ena_t = w_units_9;
          end
        end
        default: begin
          w_clr = 1'b1;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin : regs
    if (rst) begin
      r_state    <= S_IDLE;
      r_src      <= SRC_UP;
      r_timer    <= '0;
      r_repeat   <= 1'b0;
      r_pend     <= 1'b0;
      r_up_d     <= 1'b0;
      r_dn_d     <= 1'b0;
      r_up_lock  <= bus.up_btn;
      r_dn_lock  <= bus.down_btn;
      r_inc      <= 1'b0;
      r_dec      <= 1'b0;
      r_ena_u    <= 1'b0;
      r_ena_t    <= 1'b0;
      r_clr      <= 1'b0;
      r_busy     <= 1'b0;
      r_at_limit <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_src      <= w_src_nxt;
      r_timer    <= w_timer_nxt;
      r_repeat   <= w_repeat_nxt;
      r_pend     <= w_pend_nxt;
      r_up_d     <= bus.up_btn;
      r_dn_d     <= bus.down_btn;
      // Lock clears the first time the button is seen released.
      r_up_lock  <= r_up_lock & bus.up_btn;
      r_dn_lock  <= r_dn_lock & bus.down_btn;
      r_inc      <= w_inc;
      r_dec      <= w_dec;
      r_ena_u    <= w_ena_u;
      r_ena_t    <= w_ena_t;
      r_clr      <= w_clr;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_at_limit <= w_lim;
    end
  end

  assign bus.inc       = r_inc;
  assign bus.dec       = r_dec;
  assign bus.ena_u     = r_ena_u;
  assign bus.ena_t     = r_ena_t;
  assign bus.clr       = r_clr;
  assign bus.busy      = r_busy;
  assign bus.at_limit  = r_at_limit;
  assign bus.state_dbg = r_state;

endmodule

// File: tb/tb_track_sel_ctrl.sv
`timescale 1ns/1ps
module tb_track_sel_ctrl;

  localparam int DELAY  = 16;
  localparam int PERIOD = 4;
  localparam int TOP    = 99;

  // Observation vector: {inc, dec, ena_u, ena_t, clr, at_limit}
  localparam logic [5:0] V_CLR = 6'b000010;
  localparam logic [5:0] V_LIM = 6'b000001;

  localparam int OP_UP   = 0;
  localparam int OP_DN   = 1;
  localparam int OP_NXT  = 2;
  localparam int OP_CLR  = 3;
  localparam int OP_BOTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  track_sel_ctrl_if bus();

  track_sel_ctrl #(
    .MAX_TENS (4'd9),
    .MAX_UNITS(4'd9),
    .DELAY    (DELAY),
    .PERIOD   (PERIOD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- downstream BCD counter pair (environment) ----------------
  logic [3:0] m_u, m_t;
  logic       ld_en;
  logic [3:0] ld_u, ld_t;

  assign bus.units_q = m_u;
  assign bus.tens_q  = m_t;

  always @(posedge clk) begin
    if (ld_en) begin
      m_u <= ld_u;
      m_t <= ld_t;
    end else if (bus.clr) begin
      m_u <= 4'd0;
      m_t <= 4'd0;
    end else if (bus.inc) begin
      if (bus.ena_u) m_u <= (m_u == 4'd9) ? 4'd0 : m_u + 4'd1;
      if (bus.ena_t) m_t <= (m_t == 4'd9) ? 4'd0 : m_t + 4'd1;
    end else if (bus.dec) begin
      if (bus.ena_u) m_u <= (m_u == 4'd0) ? 4'd9 : m_u - 4'd1;
      if (bus.ena_t) m_t <= (m_t == 4'd0) ? 4'd9 : m_t - 4'd1;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [5:0] exp_q[$];
  int exp_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks = n_checks + 1;
    assert (obs === exp_v) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [5:0] step_vec(input int op, input int v);
    if (op == OP_UP) return {1'b1, 1'b0, 1'b1, ((v % 10) == 9), 1'b0, 1'b0};
    else             return {1'b0, 1'b1, 1'b1, ((v % 10) == 0), 1'b0, 1'b0};
  endfunction

  // Expected per-cycle outputs after a request made in cycle 0. A held
  // button steps at cycle 1, then first repeats after STEP+SETTLE+DELAY,
  // then every STEP+SETTLE+PERIOD; a refused repeat costs only PERIOD.
  // Repeats happen only while the button is still high (cycle <= hold_len).
  task automatic model(input int op, input int start, input int hold_len, input int n);
    logic [5:0] ev [0:127];
    int v, t, bound, dir;
    for (int i = 0; i < 128; i++) ev[i] = 6'b0;
    v = start;
    case (op)
      OP_NXT: begin
        if (v == TOP) begin ev[1] = V_CLR; v = 0; end
        else begin ev[1] = step_vec(OP_UP, v); v = v + 1; end
      end
      OP_CLR: begin
        ev[1] = V_CLR;
        v = 0;
      end
      OP_UP, OP_DN: begin
        bound = (op == OP_UP) ? TOP : 0;
        dir   = (op == OP_UP) ? 1 : -1;
        if (v == bound) ev[1] = V_LIM;
        else begin
          ev[1] = step_vec(op, v);
          v = v + dir;
          t = 1 + 2 + DELAY;
          while (t <= hold_len && t < 128) begin
            if (v == bound) begin
              ev[t] = V_LIM;
              t = t + PERIOD;
            end else begin
              ev[t] = step_vec(op, v);
              v = v + dir;
              t = t + 2 + PERIOD;
            end
          end
        end
      end
      default: ; // both buttons in the same cycle: nothing happens
    endcase
    exp_q.delete();
    for (int c = 1; c <= n; c++) exp_q.push_back(ev[c]);
    exp_val = v;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_value(input int v);
    @(negedge clk);
    ld_en = 1'b1;
    ld_t  = 4'(v / 10);
    ld_u  = 4'(v % 10);
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic start_op(input int op);
    case (op)
      OP_UP:   bus.up_btn     = 1'b1;
      OP_DN:   bus.down_btn   = 1'b1;
      OP_NXT:  bus.next_pulse = 1'b1;
      OP_CLR:  bus.clr_req    = 1'b1;
      default: begin bus.up_btn = 1'b1; bus.down_btn = 1'b1; end
    endcase
  endtask

  // Walks n cycles after the request edge comparing every cycle against
  // exp_q. Optional: button release at rel_c, injection of next/clr_req
  // (inj_mask bit0/bit1) for inj_len cycles from inj_c, reset at rst_c.
  task automatic run(input string tag, input int n, input int rel_c,
                     input int inj_c, input int inj_len, input logic [1:0] inj_mask,
                     input int rst_c);
    logic [5:0] obs, e;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      obs = {bus.inc, bus.dec, bus.ena_u, bus.ena_t, bus.clr, bus.at_limit};
      e   = (exp_q.size() > 0) ? exp_q.pop_front() : 6'b0;
      chk($sformatf("%s cyc%0d cmd", tag, c), 32'(obs), 32'(e));
      if (c == 1)
        chk($sformatf("%s busy", tag), 32'(bus.busy), 32'(e[5] | e[4] | e[1]));
      if (rst_c > 0 && c == rst_c + 1)
        chk($sformatf("%s busy after rst", tag), 32'(bus.busy), 32'(0));
      if (c == 1) begin bus.next_pulse = 1'b0; bus.clr_req = 1'b0; end
      if (inj_c > 0 && c == inj_c) begin
        bus.next_pulse = inj_mask[0];
        bus.clr_req    = inj_mask[1];
      end
      if (inj_c > 0 && c == inj_c + inj_len) begin
        bus.next_pulse = 1'b0;
        bus.clr_req    = 1'b0;
      end
      if (rst_c > 0 && c == rst_c)     rst = 1'b1;
      if (rst_c > 0 && c == rst_c + 1) rst = 1'b0;
      if (c == rel_c) begin bus.up_btn = 1'b0; bus.down_btn = 1'b0; end
    end
    chk($sformatf("%s value", tag), 32'(int'(m_t) * 10 + int'(m_u)), 32'(exp_val));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int op, start, len, n;
    rst = 1'b1;
    bus.up_btn = 1'b0; bus.down_btn = 1'b0;
    bus.next_pulse = 1'b0; bus.clr_req = 1'b0;
    ld_en = 1'b1; ld_u = 4'd0; ld_t = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset cmd", 32'({bus.inc, bus.dec, bus.ena_u, bus.ena_t, bus.clr, bus.at_limit}), 32'(0));
    chk("reset busy", 32'(bus.busy), 32'(0));
    rst = 1'b0;
    ld_en = 1'b0;

    // 09 + up tap -> 10 with tens carry
    set_value(9);  start_op(OP_UP);  model(OP_UP, 9, 1, 8);   run("up09", 8, 1, 0, 0, 2'b00, 0);
    // 00 + down tap -> refused, stays idle
    set_value(0);  start_op(OP_DN);  model(OP_DN, 0, 1, 8);   run("dn00", 8, 1, 0, 0, 2'b00, 0);
    // 99 + next -> wrap by clear
    set_value(99); start_op(OP_NXT); model(OP_NXT, 99, 0, 8); run("nxt99", 8, 0, 0, 0, 2'b00, 0);
    // 05 up held 40 cycles -> steps at 1,19,25,31,37, ends at 10
    set_value(5);  start_op(OP_UP);  model(OP_UP, 5, 40, 50); run("hold05", 50, 40, 0, 0, 2'b00, 0);
    // held into the upper limit: refusals every PERIOD
    set_value(97); start_op(OP_UP);  model(OP_UP, 97, 45, 55); run("hold97", 55, 45, 0, 0, 2'b00, 0);
    // both buttons rising together -> ignored
    set_value(50); start_op(OP_BOTH); model(OP_BOTH, 50, 2, 8); run("both", 8, 2, 0, 0, 2'b00, 0);
    // clr_req alone
    set_value(42); start_op(OP_CLR); model(OP_CLR, 42, 0, 8); run("clr42", 8, 0, 0, 0, 2'b00, 0);

    // next during STEP is held pending, a second one during SETTLE is dropped
    set_value(40); start_op(OP_NXT); model(OP_NXT, 40, 0, 10);
    exp_q[3] = step_vec(OP_UP, 41); exp_val = 42;
    run("pend", 10, 0, 1, 2, 2'b01, 0);

    // in HOLD, next and clr_req together: clr first, next after idle
    set_value(20); start_op(OP_UP); model(OP_UP, 20, 0, 16);
    exp_q[5] = V_CLR; exp_q[8] = step_vec(OP_UP, 0); exp_val = 1;
    run("hold_pre", 16, 12, 5, 1, 2'b11, 0);

    // reset during HOLD with button still high: no further steps
    set_value(30); start_op(OP_UP); model(OP_UP, 30, 0, 16); run("hold_rst", 16, 12, 0, 0, 2'b00, 5);
    // a fresh press works again afterwards
    set_value(31); start_op(OP_UP); model(OP_UP, 31, 1, 8); run("repress", 8, 1, 0, 0, 2'b00, 0);

    // randomized transactions
    for (int k = 0; k < 14; k++) begin
      op    = $urandom_range(0, 4);
      start = $urandom_range(0, 99);
      if ($urandom_range(0, 3) == 0) start = (op == OP_DN) ? 0 : 99;
      len   = (op == OP_UP || op == OP_DN || op == OP_BOTH) ? $urandom_range(1, 50) : 0;
      n     = len + 10;
      set_value(start);
      start_op(op);
      model(op, start, len, n);
      run($sformatf("rnd%0d_op%0d_v%0d_l%0d", k, op, start, len), n, len, 0, 0, 2'b00, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/track_sel_ctrl.md
TRACK_SEL_CTRL -- requirements
Module: track_sel_ctrl

Interface
REQ-001 Parameters: MAX_TENS, default 4'd9, tens digit of the upper limit (BCD); MAX_UNITS, default 4'd9, units digit of the upper limit (BCD); DELAY, default 16, hold cycles before the first auto-repeat; PERIOD, default 4, cycles between auto-repeats.
REQ-002 Port clk, input, 1 bit: rising-edge clock.
REQ-003 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 Port up_btn, input, 1 bit: debounced level, increment request.
REQ-005 Port down_btn, input, 1 bit: debounced level, decrement request.
REQ-006 Port next_pulse, input, 1 bit: one-cycle end-of-track advance request.
REQ-007 Port clr_req, input, 1 bit: level, zero the selection.
REQ-008 Port units_q, input, 4 bits: current BCD units digit from the downstream mod-10 counter.
REQ-009 Port tens_q, input, 4 bits: current BCD tens digit from the downstream mod-10 counter.
REQ-010 Port inc, output, 1 bit: count-up command to both digit counters.
REQ-011 Port dec, output, 1 bit: count-down command to both digit counters.
REQ-012 Port ena_u, output, 1 bit: units counter enable.
REQ-013 Port ena_t, output, 1 bit: tens counter enable.
REQ-014 Port clr, output, 1 bit: reset pulse to both digit counters.
REQ-015 Port busy, output, 1 bit: high in any state other than IDLE.
REQ-016 Port at_limit, output, 1 bit: one-cycle pulse when a step is rejected.

Function
REQ-017 All outputs shall be registered; inc, dec, ena_u, ena_t and clr shall each be high for exactly one cycle per command.
REQ-018 The FSM shall have four states: IDLE, STEP, SETTLE, HOLD.
REQ-019 In IDLE, arbitration priority shall be clr_req > pending next > up_btn rising edge > down_btn rising edge; a rising edge on both buttons in the same cycle shall be ignored.
REQ-020 A granted request shall move IDLE->STEP on the next edge; the command shall appear on the outputs during the STEP cycle (latency 1 cycle from the request cycle).
REQ-021 Up step: inc=1, ena_u=1, and ena_t=1 only if units_q==9.
REQ-022 Down step: dec=1, ena_u=1, and ena_t=1 only if units_q==0.
REQ-023 An up or button step at {tens_q,units_q}=={MAX_TENS,MAX_UNITS} shall be rejected: no STEP, at_limit=1 for one cycle.
REQ-024 A down step at 00 shall be rejected in the same way.
REQ-025 A next step at the limit shall issue clr instead of inc (wrap to 00), with no at_limit pulse.
REQ-026 A next_pulse arriving while busy shall set a one-deep pending flag; a second pulse before it is served shall be dropped.
REQ-027 STEP shall always be followed by exactly one SETTLE cycle with all commands low.
REQ-028 From SETTLE, if the command came from a button that is still held, the FSM shall enter HOLD with timer=DELAY; otherwise it shall return to IDLE.
REQ-029 In HOLD, release of the active button shall return the FSM to IDLE on the next edge.
REQ-030 In HOLD, clr_req or pending next shall preempt, going to STEP with that command.
REQ-031 In HOLD, timer expiry shall re-evaluate the limit and go to STEP (repeat), or pulse at_limit and reload; every reload after the first shall use PERIOD.
REQ-032 The timer width shall be sized to hold max(DELAY, PERIOD) with no wrap.

Reset
REQ-033 With rst=1 at a clock edge: state=IDLE, all outputs 0, pending flag 0, timer 0, button edge registers 0.
REQ-034 rst shall override any in-progress STEP/HOLD; no command pulse shall follow reset.

Verification
REQ-035 Value 09, up_btn rising -> STEP cycle with inc=1, ena_u=1, ena_t=1; the counters read 10; at_limit=0.
REQ-036 Value 00, down_btn pulse -> no ena_u/ena_t, at_limit=1 for one cycle, busy stays 0.
REQ-037 MAX=99, value 99, next_pulse -> clr=1 for one cycle; the counters read 00.
REQ-038 Value 05, up_btn held 40 cycles with DELAY=16, PERIOD=4 -> steps at cycles 1, 19, 25, 31, 37 after the edge (STEP+SETTLE+timer); final value 10.
REQ-039 up_btn held in HOLD, next_pulse and clr_req asserted the same cycle -> clr served first, next served after return to IDLE.
REQ-040 rst asserted during HOLD -> the next cycle has busy=0 and no inc/dec even though up_btn is still high; a new rising edge is required.
